preg_alloc_ctrl: RTL and testbench
==================================

# preg_alloc_ctrl

Physical-register allocation controller sitting between decode/rename and the physical register file. Tracks free physical registers as a speculative and a committed bitmap. Grants up to two new destination registers per cycle to in-order rename lanes, and reclaims superseded mappings at ROB commit. On pipeline flush it restores the speculative free set from the committed one, then holds allocation for a fixed recovery window.

## Interface
Parameters:
- `NPHY`, 64: number of physical registers. Preg 0 is the hardwired zero and is never allocated.
- `RECOVER_CYCLES`, 1: cycles allocation is blocked after a flush (≥1).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `alloc0_req`, in, 1: lane 0 needs a destination preg.
- `alloc0_gnt`, out, 1: lane 0 granted this cycle.
- `alloc0_phy`, out, PW: preg granted to lane 0. PW = $clog2(NPHY).
- `alloc1_req`, in, 1: lane 1 request. Present only with the macro.
- `alloc1_gnt`, out, 1: lane 1 grant. Present only with the macro.
- `alloc1_phy`, out, PW: lane 1 preg. Present only with the macro.
- `commit_valid`, in, 1: ROB retires one instruction.
- `commit_rd_phy`, in, PW: retired instruction's new mapping (0 = none).
- `commit_rd_origin`, in, PW: mapping it superseded (0 = none).
- `flush`, in, 1: squash all uncommitted state.
- `free_count`, out, CW: registered count of speculatively free pregs. CW = $clog2(NPHY+1).
- `recovering`, out, 1: FSM is in RECOVER.
- `err_double_free`, out, 1: sticky; set when a release targets an already-free preg.

## Operation
- Reset:
  - spec_free = committed_free = all ones except bit 0.
  - free_count = NPHY-1; FSM = RUN.
  - All grants, `recovering` and `err_double_free` are 0.
- FSM states: RUN and RECOVER.
  - RUN → RECOVER on `flush`, which loads the recovery counter with RECOVER_CYCLES.
  - In RECOVER the counter decrements each cycle; the FSM returns to RUN when the counter reaches 1.
  - A `flush` arriving during RECOVER reloads the counter.
- Grant rules (combinational, same cycle):
  - `alloc0_phy` = lowest set bit of spec_free. `alloc1_phy` = second-lowest set bit.
  - `alloc0_gnt` = alloc0_req & state==RUN & ~flush & free_count≥1.
  - `alloc1_gnt` = alloc1_req & alloc0_gnt & free_count≥2. Lane 1 is never granted without lane 0, which preserves program order.
  - `*_phy` are don't-care when the corresponding grant is 0.
- Edge updates:
  - Each granted preg: its spec_free bit is cleared.
  - commit_valid & commit_rd_origin≠0: that bit is set in both spec_free and committed_free.
  - commit_valid & commit_rd_phy≠0: that bit is cleared in committed_free.
- free_count is next-state: prior value − grants + speculative releases.
- Flush at an edge:
  - spec_free ← committed_free including this cycle's commit updates.
  - free_count ← popcount of that value, kept as an incrementally maintained committed counter.
  - Same-cycle grants are already 0.
- A release and an allocation in the same cycle: the released preg becomes visible to the allocator only on the next cycle (no bypass).
- Double free: a release whose bit is already set in spec_free sets `err_double_free`. The bitmap still ends with the bit set.

## Timing
- Grant latency: 0 cycles from request.
- Release-to-reuse latency: 1 cycle.
- After flush asserted in cycle T: grants are 0 in T through T+RECOVER_CYCLES, and resume in T+RECOVER_CYCLES+1.
- Reset asserted mid-operation: all state is cleared immediately (asynchronous). First grant is possible in the first cycle after deassertion.

## Configuration
- `PREG_DUAL_ALLOC_EN` defined: lane 1 ports and the second-lowest picker exist; up to two grants per cycle.
- Not defined: lane 1 ports are absent; single grant per cycle; free_count decrements by at most 1.

## Structure
- Common package holds:
  - `phy_addr_t`.
  - `NPHY` default.
  - `preg_mask_t` (logic [NPHY-1:0]).
- Sub-module `preg_pick2`: combinational finder of the lowest and second-lowest set bits of a mask, with valid flags. The lane-1 output is unused when the macro is off.

## Test plan
- Reset, then alloc0_req held 2 cycles → phys 1 then 2; free_count 63→62→61.
- Macro on, both requests in one cycle from reset → alloc0_phy=1, alloc1_phy=2, both granted; free_count=61.
- Allocate 1 and 2, commit rd_phy=1 origin=0, then flush → 2 free again, 1 held; free_count=62; grants 0 for RECOVER_CYCLES; next grant returns 2.
- Drain to free_count=0 with alloc0_req held → gnt=0. Commit origin=5 → next cycle grants 5.
- Commit origin=7 while 7 is already free → err_double_free=1 and stays 1 until rst.
- Assert rst during RECOVER → recovering=0, free_count=63 immediately.

Source files
------------

// File: rtl/preg_alloc_ctrl_pkg.sv
// Shared types and defaults for the physical-register allocation controller.
package preg_alloc_ctrl_pkg;
  localparam int NPHY_DEFAULT = 64;
  localparam int PW_DEFAULT   = $clog2(NPHY_DEFAULT);

  typedef logic [PW_DEFAULT-1:0]   phy_addr_t;
  typedef logic [NPHY_DEFAULT-1:0] preg_mask_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } rec_state_e;
endpackage

// File: rtl/preg_alloc_ctrl_pick2.sv
// Lowest and second-lowest set-bit finder over a free mask.
module preg_pick2 #(
  parameter int N = 64,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] mask_i,
  output logic         v0_o,
  output logic [W-1:0] i0_o,
  output logic         v1_o,
  output logic [W-1:0] i1_o
);
  always_comb begin
    v0_o = 1'b0;
    i0_o = '0;
    v1_o = 1'b0;
    i1_o = '0;
    for (int i = 0; i < N; i++) begin
      if (mask_i[i]) begin
        if (!v0_o) begin
          v0_o = 1'b1;
          i0_o = i[W-1:0];
        end else if (!v1_o) begin
          v1_o = 1'b1;
          i1_o = i[W-1:0];
        end
      end
    end
  end
endmodule

// File: rtl/preg_alloc_ctrl.sv
// Physical-register allocator: speculative/committed free bitmaps, flush recovery.
// Define PREG_DUAL_ALLOC_EN to add the second rename lane (two grants per cycle).
module preg_alloc_ctrl
  import preg_alloc_ctrl_pkg::*;
#(
  parameter int NPHY           = NPHY_DEFAULT,
  parameter int RECOVER_CYCLES = 1,
  localparam int PW            = $clog2(NPHY),
  localparam int CW            = $clog2(NPHY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc0_req,
  output logic          alloc0_gnt,
  output logic [PW-1:0] alloc0_phy,
`ifdef PREG_DUAL_ALLOC_EN
  input  logic          alloc1_req,
  output logic          alloc1_gnt,
  output logic [PW-1:0] alloc1_phy,
`endif
  input  logic          commit_valid,
  input  logic [PW-1:0] commit_rd_phy,
  input  logic [PW-1:0] commit_rd_origin,
  input  logic          flush,
  output logic [CW-1:0] free_count,
  output logic          recovering,
  output logic          err_double_free
);
  localparam int RCW = $clog2(RECOVER_CYCLES + 1);

  logic [NPHY-1:0] spec_free_q, spec_free_d;
  logic [NPHY-1:0] cmt_free_q, cmt_free_d;
  logic [CW-1:0]   free_cnt_q, free_cnt_d;
  logic [CW-1:0]   cmt_cnt_q, cmt_cnt_d;
  rec_state_e      state_q, state_d;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic            err_q, err_d;

  logic            pk_v0, pk_v1;
  logic [PW-1:0]   pk_i0, pk_i1;
  logic            gnt0, gnt1;
  logic            run_ok;
  logic            rel_v, clr_v, rel_dup, rel_inc;
  logic [NPHY-1:0] grant_mask;
  logic            unused_pick;

  preg_pick2 #(.N(NPHY)) u_pick (
    .mask_i (spec_free_q),
    .v0_o   (pk_v0),
    .i0_o   (pk_i0),
    .v1_o   (pk_v1),
    .i1_o   (pk_i1)
  );

  // Grants are purely combinational; reset and flush suppress them in-cycle.
  assign run_ok = (state_q == ST_RUN) && !flush && !rst;
  assign gnt0   = alloc0_req && run_ok && (free_cnt_q >= CW'(1));

`ifdef PREG_DUAL_ALLOC_EN
  assign gnt1        = alloc1_req && gnt0 && (free_cnt_q >= CW'(2));
  assign alloc1_gnt  = gnt1;
  assign alloc1_phy  = pk_i1;
  assign unused_pick = pk_v0 ^ pk_v1;
`else
  assign gnt1        = 1'b0;
  assign unused_pick = ^{pk_v0, pk_v1, pk_i1};
`endif

  assign alloc0_gnt = gnt0;
  assign alloc0_phy = pk_i0;

  assign rel_v   = commit_valid && (commit_rd_origin != '0);
  assign clr_v   = commit_valid && (commit_rd_phy != '0);
  assign rel_dup = rel_v && spec_free_q[commit_rd_origin];
  // A duplicate release only adds a free preg if that preg is being granted this cycle.
  assign rel_inc = rel_v && (!spec_free_q[commit_rd_origin] || grant_mask[commit_rd_origin]);

  always_comb begin
    grant_mask = '0;
    if (gnt0) grant_mask[pk_i0] = 1'b1;
    if (gnt1) grant_mask[pk_i1] = 1'b1;

    spec_free_d = spec_free_q & ~grant_mask;
    if (rel_v) spec_free_d[commit_rd_origin] = 1'b1;

    cmt_free_d = cmt_free_q;
    cmt_cnt_d  = cmt_cnt_q;
    if (rel_v) begin
      if (!cmt_free_q[commit_rd_origin]) cmt_cnt_d = cmt_cnt_d + CW'(1);
      cmt_free_d[commit_rd_origin] = 1'b1;
    end
    if (clr_v) begin
      if (cmt_free_d[commit_rd_phy]) cmt_cnt_d = cmt_cnt_d - CW'(1);
      cmt_free_d[commit_rd_phy] = 1'b0;
    end

    free_cnt_d = free_cnt_q - CW'(gnt0) - CW'(gnt1) + CW'(rel_inc);

    // Flush rolls the speculative view back to the committed one, incl. this cycle's commit.
    if (flush) begin
      spec_free_d = cmt_free_d;
      free_cnt_d  = cmt_cnt_d;
    end

    err_d = err_q | rel_dup;
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_RECOVER;
          rcnt_d  = RCW'(RECOVER_CYCLES);
        end
      end
      ST_RECOVER: begin
        if (flush)                    rcnt_d  = RCW'(RECOVER_CYCLES);
        else if (rcnt_q <= RCW'(1))   state_d = ST_RUN;
        else                          rcnt_d  = rcnt_q - RCW'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_free_q <= {{(NPHY-1){1'b1}}, 1'b0};
      cmt_free_q  <= {{(NPHY-1){1'b1}}, 1'b0};
      free_cnt_q  <= CW'(NPHY - 1);
      cmt_cnt_q   <= CW'(NPHY - 1);
      state_q     <= ST_RUN;
      rcnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      spec_free_q <= spec_free_d;
      cmt_free_q  <= cmt_free_d;
      free_cnt_q  <= free_cnt_d;
      cmt_cnt_q   <= cmt_cnt_d;
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      err_q       <= err_d;
    end
  end

  assign free_count      = free_cnt_q;
  assign recovering      = (state_q == ST_RECOVER);
  assign err_double_free = err_q;
endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Directed bench for preg_alloc_ctrl with a grant scoreboard; honours PREG_DUAL_ALLOC_EN.
module tb_preg_alloc_ctrl;
  import preg_alloc_ctrl_pkg::*;

  localparam int NPHY = 64;
  localparam int RC   = 2;
  localparam int CW   = $clog2(NPHY + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc0_req;
  logic          alloc0_gnt;
  phy_addr_t     alloc0_phy;
`ifdef PREG_DUAL_ALLOC_EN
  logic          alloc1_req;
  logic          alloc1_gnt;
  phy_addr_t     alloc1_phy;
`endif
  logic          commit_valid;
  phy_addr_t     commit_rd_phy;
  phy_addr_t     commit_rd_origin;
  logic          flush;
  logic [CW-1:0] free_count;
  logic          recovering;
  logic          err_double_free;

  int n_chk  = 0;
  int n_pass = 0;
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  preg_alloc_ctrl #(.NPHY(NPHY), .RECOVER_CYCLES(RC)) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc0_req       (alloc0_req),
    .alloc0_gnt       (alloc0_gnt),
    .alloc0_phy       (alloc0_phy),
`ifdef PREG_DUAL_ALLOC_EN
    .alloc1_req       (alloc1_req),
    .alloc1_gnt       (alloc1_gnt),
    .alloc1_phy       (alloc1_phy),
`endif
    .commit_valid     (commit_valid),
    .commit_rd_phy    (commit_rd_phy),
    .commit_rd_origin (commit_rd_origin),
    .flush            (flush),
    .free_count       (free_count),
    .recovering       (recovering),
    .err_double_free  (err_double_free)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive lane requests and push the expected grant (-1 = none) for this cycle.
  task automatic drv(input bit r0, input int e0, input bit r1 = 1'b0, input int e1 = -1);
    alloc0_req = r0;
    q0.push_back(e0);
`ifdef PREG_DUAL_ALLOC_EN
    alloc1_req = r1;
    q1.push_back(e1);
`else
    if (r1 || e1 >= 0) $display("note: lane 1 stimulus ignored in single-lane build");
`endif
  endtask

  // Compare grants mid-cycle against the scoreboard, then advance one clock.
  task automatic cycle();
    int e0;
    @(negedge clk);
    e0 = q0.pop_front();
    chk("gnt0", alloc0_gnt, (e0 >= 0));
    if (e0 >= 0) chk("phy0", alloc0_phy, e0);
`ifdef PREG_DUAL_ALLOC_EN
    begin
      int e1;
      e1 = q1.pop_front();
      chk("gnt1", alloc1_gnt, (e1 >= 0));
      if (e1 >= 0) chk("phy1", alloc1_phy, e1);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alloc0_req = 1'b1; flush = 1'b0;
    commit_valid = 1'b0; commit_rd_phy = '0; commit_rd_origin = '0;
`ifdef PREG_DUAL_ALLOC_EN
    alloc1_req = 1'b0;
`endif
    @(negedge clk);
    chk("rst_fc", free_count, 63);
    chk("rst_rec", recovering, 0);
    chk("rst_err", err_double_free, 0);
    chk("rst_gnt", alloc0_gnt, 0);
    alloc0_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back single allocations from reset.
    drv(1, 1); cycle(); chk("fc_a1", free_count, 62);
    drv(1, 2); cycle(); chk("fc_a2", free_count, 61);

    // Commit preg 1, then flush: 2 returns, 1 stays held.
    commit_valid = 1'b1; commit_rd_phy = 6'd1; commit_rd_origin = '0;
    drv(0, -1); cycle();
    commit_valid = 1'b0; commit_rd_phy = '0;
    chk("fc_cmt", free_count, 61);
    flush = 1'b1; drv(1, -1); cycle(); flush = 1'b0;
    chk("fc_flush", free_count, 62);
    chk("rec_t1", recovering, 1);
    drv(1, -1); cycle(); chk("rec_t2", recovering, 1);
    drv(1, -1); cycle(); chk("rec_t3", recovering, 0);
    drv(1, 2);  cycle(); chk("fc_resume", free_count, 61);

    // Flush again during recovery: the window restarts.
    flush = 1'b1; drv(1, -1); cycle();
    drv(1, -1); cycle(); flush = 1'b0;
    drv(1, -1); cycle();
    drv(1, -1); cycle(); chk("rec_reflush", recovering, 0);
    drv(1, 2);  cycle(); chk("fc_reflush", free_count, 61);

    // Drain every remaining preg in ascending order.
    for (int p = 3; p < NPHY; p++) begin
      drv(1, p); cycle();
    end
    chk("fc_empty", free_count, 0);
    drv(1, -1); cycle(); chk("fc_empty2", free_count, 0);

    // Release preg 5 with a request pending: no same-cycle bypass.
    commit_valid = 1'b1; commit_rd_origin = 6'd5;
    drv(1, -1); cycle();
    commit_valid = 1'b0; commit_rd_origin = '0;
    chk("fc_rel5", free_count, 1);
    drv(1, 5); cycle(); chk("fc_reuse5", free_count, 0);

    // Release 7 legitimately, then again as a double free.
    commit_valid = 1'b1; commit_rd_origin = 6'd7;
    drv(0, -1); cycle();
    chk("err_clean", err_double_free, 0);
    chk("fc_rel7", free_count, 1);
    drv(0, -1); cycle();
    commit_valid = 1'b0; commit_rd_origin = '0;
    chk("err_set", err_double_free, 1);
    drv(0, -1); cycle();
    drv(0, -1); cycle();
    chk("err_sticky", err_double_free, 1);
    drv(1, 7); cycle();
    chk("err_sticky2", err_double_free, 1);

    // Asynchronous reset while recovering.
    flush = 1'b1; drv(0, -1); cycle(); flush = 1'b0;
    chk("rec_pre_rst", recovering, 1);
    alloc0_req = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_rec", recovering, 0);
    chk("arst_fc", free_count, 63);
    chk("arst_err", err_double_free, 0);
    chk("arst_gnt", alloc0_gnt, 0);
    alloc0_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef PREG_DUAL_ALLOC_EN
    drv(1, 1, 1, 2);  cycle(); chk("fc_dual", free_count, 61);
    drv(0, -1, 1, -1); cycle(); chk("fc_lane1_only", free_count, 61);
    drv(1, 3, 0, -1); cycle(); chk("fc_dual_l0", free_count, 60);
`else
    drv(1, 1); cycle(); chk("fc_post_rst", free_count, 62);
    drv(1, 2); cycle(); chk("fc_post_rst2", free_count, 61);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
